// File: rtl/lilme_pkg.sv
// Shared encodings for the lilme stream controller: opcodes, FSM states, engine op.
package lilme_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_LOAD_A = 3'b001,
    OP_LOAD_B = 3'b010,
    OP_MULT   = 3'b011,
    OP_ADD    = 3'b100,
    OP_READ   = 3'b101
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_READ
  } state_e;

  localparam logic ENG_OP_MUL = 1'b0;
  localparam logic ENG_OP_ADD = 1'b1;

endpackage

// File: rtl/lilme_wd_counter.sv
// Engine wait watchdog: counts cycles while enabled, flags the last allowed cycle.
module lilme_wd_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt;

  // Count up from 0 on every enabled cycle; cleared whenever the FSM is outside WAIT.
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lilme_stream_ctrl.sv
// Command-driven controller: loads A/B matrices, kicks the engine, streams results out.
module lilme_stream_ctrl
  import lilme_pkg::*;
#(
  parameter int DW      = 32,
  parameter int N       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic                  eng_start,
  output logic                  eng_op,
  input  logic                  eng_done,
  output logic [N*N*DW-1:0]     eng_a,
  output logic [N*N*DW-1:0]     eng_b,
  input  logic [N*N*2*DW-1:0]   eng_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  busy,
  output logic                  err
);

  localparam int NE = N * N;
  localparam int LW = $clog2(NE);
  localparam int KW = $clog2(2 * NE);

  state_e state, state_nxt;

  logic [NE-1:0][DW-1:0]   a_buf, b_buf;
  logic [NE-1:0][2*DW-1:0] res_buf;
  logic [2*DW-1:0]         res_word;

  logic [LW-1:0] ld_idx;
  logic [KW-1:0] rd_k;
  logic          tgt_b;
  logic          res_avail;

  logic cmd_fire, ld_fire, rd_fire, cap_res, set_err;
  logic wd_expire;

  lilme_wd_counter #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clr    (state != ST_WAIT),
    .en     (state == ST_WAIT),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus handshake strobes and state-derived outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    eng_start = 1'b0;
    cmd_fire  = 1'b0;
    ld_fire   = 1'b0;
    rd_fire   = 1'b0;
    cap_res   = 1'b0;
    set_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_fire = 1'b1;
          case (cmd_op)
            OP_NOP:              ;
            OP_LOAD_A, OP_LOAD_B: state_nxt = ST_LOAD;
            OP_MULT, OP_ADD:     state_nxt = ST_START;
            OP_READ: begin
              // Nothing to stream yet: flag it and stay put, out_valid never rises.
              if (res_avail) state_nxt = ST_READ;
              else           set_err   = 1'b1;
            end
            default:             set_err   = 1'b1;
          endcase
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_fire = 1'b1;
          if (ld_idx == LW'(NE - 1)) state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        eng_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the final allowed cycle still wins over the timeout.
        if (eng_done) begin
          cap_res   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wd_expire) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rd_fire = 1'b1;
          if (rd_k == KW'(2 * NE - 1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: load target/index, engine op, read index, sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_b     <= 1'b0;
      ld_idx    <= '0;
      rd_k      <= '0;
      eng_op    <= ENG_OP_MUL;
      res_avail <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        ld_idx <= '0;
        rd_k   <= '0;
      end
      if (cmd_fire && (cmd_op == OP_LOAD_A || cmd_op == OP_LOAD_B))
        tgt_b <= (cmd_op == OP_LOAD_B);
      if (cmd_fire && cmd_op == OP_MULT) eng_op <= ENG_OP_MUL;
      if (cmd_fire && cmd_op == OP_ADD)  eng_op <= ENG_OP_ADD;
      if (ld_fire) ld_idx <= ld_idx + 1'b1;
      if (rd_fire) rd_k   <= rd_k + 1'b1;
      if (cap_res) res_avail <= 1'b1;
      if (set_err) err       <= 1'b1;
    end
  end

  // Operand and result storage; result only replaced by a successful compute.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_buf   <= '0;
      b_buf   <= '0;
      res_buf <= '0;
    end else begin
      if (ld_fire && !tgt_b) a_buf[ld_idx] <= in_data;
      if (ld_fire &&  tgt_b) b_buf[ld_idx] <= in_data;
      if (cap_res)           res_buf       <= eng_res;
    end
  end

  // Even k streams the low half of element k/2, odd k the high half.
  assign res_word = res_buf[rd_k[KW-1:1]];
  assign out_data = rd_k[0] ? res_word[2*DW-1:DW] : res_word[DW-1:0];

  assign eng_a = a_buf;
  assign eng_b = b_buf;
  assign busy  = (state != ST_IDLE);

endmodule

// File: doc/lilme_stream_ctrl.md
LILME_STREAM_CTRL -- requirements
Module: lilme_stream_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- DW, 32: element data width.
- N, 4: square matrix dimension; N >= 2.
- TIMEOUT, 1024: maximum engine wait cycles; TIMEOUT >= 2.
REQ-002 Ports (name, direction, width, meaning); the block SHALL provide these:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- cmd_valid, in, 1: command present.
- cmd_ready, out, 1: command accepted when both valid and ready are high.
- cmd_op, in, 3: opcode.
- in_valid, in, 1: load word present.
- in_ready, out, 1: load word accepted when both valid and ready are high.
- in_data, in, DW: load word.
- eng_start, out, 1: one-cycle compute pulse.
- eng_op, out, 1: compute operation; 0 = multiply, 1 = add.
- eng_done, in, 1: engine result valid, sampled in WAIT only.
- eng_a, out, N*N*DW: A buffer, row-major; element (r,c) at [(r*N+c)*DW +: DW].
- eng_b, out, N*N*DW: B buffer, same layout as eng_a.
- eng_res, in, N*N*2*DW: engine result, row-major, 2*DW per element.
- out_valid, out, 1: result word present.
- out_ready, in, 1: result word consumed when both valid and ready are high.
- out_data, out, DW: result word.
- busy, out, 1: high in every state except IDLE.
- err, out, 1: sticky error flag.

Function
REQ-003 Opcodes SHALL be: 000 NOP, 001 LOAD_A, 010 LOAD_B, 011 MULT, 100 ADD, 101 READ; 110 and 111 are illegal.
REQ-004 States SHALL be IDLE, LOAD, START, WAIT, READ.
REQ-005 cmd_ready SHALL be high only in IDLE; commands presented outside IDLE SHALL stall and never be dropped.
REQ-006 Accepting NOP SHALL leave the state unchanged; accepting an illegal opcode SHALL set err and leave the state unchanged.
REQ-007 LOAD_A or LOAD_B SHALL enter LOAD with the target latched, load index = 0, and in_ready = 1.
REQ-008 In LOAD, each in handshake SHALL write in_data to element[index] of the target and increment index; in_valid=0 cycles SHALL hold index.
REQ-009 The handshake at index N*N-1 SHALL return the block to IDLE on the next cycle; the other buffer SHALL be untouched.
REQ-010 MULT or ADD SHALL enter START; eng_op SHALL be latched (0 for MULT, 1 for ADD).
REQ-011 START SHALL last exactly one cycle with eng_start=1, then go to WAIT.
REQ-012 In WAIT, eng_done=1 SHALL capture eng_res into the internal result buffer, set res_avail, and return to IDLE.
REQ-013 In WAIT, a cycle counter SHALL count from 0; reaching TIMEOUT-1 without eng_done SHALL set err, keep the old result buffer and res_avail, and return to IDLE.
REQ-014 eng_done arriving on the same cycle the counter reaches TIMEOUT-1 SHALL count as success, not timeout.
REQ-015 READ with res_avail=1 SHALL enter READ with word index = 0.
REQ-016 READ with res_avail=0 SHALL set err and stay in IDLE; out_valid SHALL never assert in this case.
REQ-017 In READ, out_valid SHALL be 1, and out_data SHALL be element[k/2] low half for even k and high half for odd k.
REQ-018 In READ, each out handshake SHALL increment k; the handshake at k = 2*N*N-1 SHALL return the block to IDLE.
REQ-019 While out_valid=1 and out_ready=0, out_data and k SHALL hold stable.
REQ-020 READ SHALL be repeatable: the result buffer persists until the next successful compute.
REQ-021 A and B buffers SHALL be driven continuously on eng_a and eng_b, with zero latency from register to port.
REQ-022 err SHALL clear only on reset.

Reset
REQ-023 On reset, all of the following SHALL take effect on the next rising edge of clk:
- state = IDLE.
- A, B and result buffers = 0.
- All counters = 0.
- res_avail = 0, err = 0, eng_start = 0, eng_op = 0.
- out_valid = 0, in_ready = 0, cmd_ready = 1 from the first cycle after release.
REQ-024 Reset asserted in any state SHALL abort the operation; no partial handshake SHALL complete in that cycle.

Structure
REQ-025 A shared package lilme_pkg SHALL hold the opcode enum, the state enum, and the eng_op encoding.
REQ-026 A single sub-module lilme_wd_counter (the WAIT timeout counter: clear, enable, expire) is natural; buffers and the FSM SHALL stay in the top module.

Verification
REQ-027 The bench SHALL cover these directed scenarios (DW=32, N=4, TIMEOUT=16 unless stated):
- Load A = identity and B = 1..16, issue MULT with a model engine returning A*B, then READ with out_ready=1 → 32 words; word 2j = j+1, word 2j+1 = 0; busy falls after word 31.
- Backpressure: drop out_ready for 3 cycles at k=5 → out_data = 0 (high half of element 2) held for 3 cycles; no skipped or repeated words.
- READ immediately after reset → err=1, out_valid stays 0, cmd_ready=1 on the next cycle.
- Timeout: engine never asserts done → err=1 exactly 16 cycles after eng_start; prior result still readable.
- Reset at load index 7 of LOAD_A, then full LOAD_A of 16 words → buffer contains only the new words, starting at index 0.
- eng_done at WAIT count 15 → success, err=0, res_avail=1.
